// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver and transmitter.
// Holds the receive FSM states, frame defaults and the parity helper.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_MAX_BITS   = 16;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Parity generator/checker shared by both directions. Generate mode
    // returns the parity bit to send; check mode returns the mismatch
    // between the received bit and the expected one.
    function automatic logic uart_parity(
        input logic [UART_MAX_BITS-1:0] data,
        input logic                     odd,
        input logic                     check_en,
        input logic                     rx_bit
    );
        logic w_exp;
        w_exp = (^data) ^ odd;
        return check_en ? (w_exp ^ rx_bit) : w_exp;
    endfunction

endpackage

// File: rtl/uart_receiver_core_if.sv
// Host-side bundle of the UART receiver: serial input, tick,
// parity configuration and the received word with its status flags.
interface uart_receiver_core_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS
);
    logic                 rx_serial;
    logic                 sample_tick;
    logic                 parity_en;
    logic                 parity_odd;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 parity_error;
    logic                 framing_error;
    logic                 busy;

    modport master (
        output rx_serial,
        output sample_tick,
        output parity_en,
        output parity_odd,
        input  data_out,
        input  data_valid,
        input  parity_error,
        input  framing_error,
        input  busy
    );

    modport slave (
        input  rx_serial,
        input  sample_tick,
        input  parity_en,
        input  parity_odd,
        output data_out,
        output data_valid,
        output parity_error,
        output framing_error,
        output busy
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus falling-edge detect.
// All flops reset to 1 so a reset looks like an idle line.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_rx,
    output logic o_rx_s,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Metastability chain, then one extra stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_rx;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rx_s = r_sync;
    assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/uart_receiver_core.sv
// Oversampling UART receiver: start validation, LSB-first data,
// optional parity and stop check, one-cycle delivery pulse.
module uart_receiver_core
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input logic                 clk,
    input logic                 rst_n,
    uart_receiver_core_if.slave bus
);

    localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    rx_state_t            r_state;
    logic [CW-1:0]        r_cnt;
    logic [BW-1:0]        r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_en;
    logic                 r_par_odd;
    logic                 r_par_err;
    logic                 r_armed;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_busy;

    logic w_rx_s;
    logic w_fall;
    logic w_mid;
    logic w_end;
    logic w_mismatch;

    uart_rx_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_rx   (bus.rx_serial),
        .o_rx_s (w_rx_s),
        .o_fall (w_fall)
    );

    assign w_mid = (r_cnt == CNT_MID);
    assign w_end = (r_cnt == CNT_LAST);
    assign w_mismatch = uart_parity(
        UART_MAX_BITS'(r_shift), r_par_odd, 1'b1, w_rx_s);

    // Receive FSM: every step is gated by sample_tick. A start is only
    // accepted after a high-to-low edge since the last frame, so a held
    // break line does not keep re-triggering frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RX_IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_par_en  <= 1'b0;
            r_par_odd <= 1'b0;
            r_par_err <= 1'b0;
            r_armed   <= 1'b0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_fall) begin
                r_armed <= 1'b1;
            end
            if (bus.sample_tick) begin
                unique case (r_state)
                    RX_IDLE: begin
                        if (!w_rx_s && r_armed) begin
                            r_state <= RX_START;
                            r_cnt   <= '0;
                            r_armed <= 1'b0;
                        end
                    end
                    RX_START: begin
                        if (w_mid) begin
                            r_cnt <= '0;
                            if (w_rx_s) begin
                                r_state <= RX_IDLE;
                            end else begin
                                r_state   <= RX_DATA;
                                r_busy    <= 1'b1;
                                r_bit     <= '0;
                                r_par_en  <= bus.parity_en;
                                r_par_odd <= bus.parity_odd;
                                r_par_err <= 1'b0;
                            end
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    RX_DATA: begin
                        if (w_end) begin
                            r_cnt   <= '0;
                            r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                            if (r_bit == BIT_LAST) begin
                                r_state <= r_par_en ? RX_PARITY : RX_STOP;
                            end else begin
                                r_bit <= r_bit + BW'(1);
                            end
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    RX_PARITY: begin
                        if (w_end) begin
                            r_cnt     <= '0;
                            r_par_err <= w_mismatch;
                            r_state   <= RX_STOP;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    RX_STOP: begin
                        if (w_end) begin
                            r_cnt   <= '0;
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                            r_ferr  <= ~w_rx_s;
                            r_perr  <= r_par_err;
                            r_busy  <= 1'b0;
                            r_armed <= 1'b0;
                            r_state <= RX_IDLE;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    default: begin
                        r_state <= RX_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.data_out      = r_data;
    assign bus.data_valid    = r_valid;
    assign bus.parity_error  = r_perr;
    assign bus.framing_error = r_ferr;
    assign bus.busy          = r_busy;

endmodule
